// File: rtl/alu_iter.sv
// alu_iter: multi-cycle ALU that processes the operands SLICE bits per clock,
// carrying between chunks through a register, then publishes results in FIN.
module alu_iter #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       op_i,
    input  logic [2:0]       comp_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             overflow_o
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] K_LAST = CW'(N - 1);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_CMP = 4'b0111;

    localparam logic [2:0] CMP_SLT = 3'b000;
    localparam logic [2:0] CMP_SGT = 3'b001;
    localparam logic [2:0] CMP_SLE = 3'b010;
    localparam logic [2:0] CMP_SGE = 3'b011;
    localparam logic [2:0] CMP_SEQ = 3'b110;
    localparam logic [2:0] CMP_SNE = 3'b100;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic [3:0]       op_q;
    logic [2:0]       comp_q;
    logic [CW-1:0]    k_q;
    logic             carry_q;
    logic             busy_q, done_q, zero_q, cout_q, ovf_q;
    logic [WIDTH-1:0] result_q;

    logic             is_sub;
    logic [SLICE-1:0] a_ch, b_ch, b_eff, chunk_res;
    logic [SLICE:0]   sum_ch;
    logic [WIDTH-1:0] res_d, fin_res_d;
    logic             ovf_d, less, equal, flag, cmp_ok, fin_cout_d, fin_ovf_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        is_sub    = (op_q == OP_SUB) || (op_q == OP_CMP);
        a_ch      = a_q[k_q*SLICE +: SLICE];
        b_ch      = b_q[k_q*SLICE +: SLICE];
        b_eff     = is_sub ? ~b_ch : b_ch;
        sum_ch    = {1'b0, a_ch} + {1'b0, b_eff} + (SLICE+1)'(carry_q);

        case (op_q)
            OP_AND:  chunk_res = a_ch & b_ch;
            OP_OR:   chunk_res = a_ch | b_ch;
            OP_NOR:  chunk_res = ~(a_ch | b_ch);
            default: chunk_res = sum_ch[SLICE-1:0];
        endcase

        res_d = res_q;
        res_d[k_q*SLICE +: SLICE] = chunk_res;

        // Same-sign inputs with a differently signed sum: carry-in and carry-out of the MSB differ.
        ovf_d = (a_ch[SLICE-1] == b_eff[SLICE-1]) && (sum_ch[SLICE-1] != a_ch[SLICE-1]);
        less  = res_d[WIDTH-1] ^ ovf_d;
        equal = (res_d == '0);

        flag   = 1'b0;
        cmp_ok = 1'b1;
        case (comp_q)
            CMP_SLT: flag = less;
            CMP_SGT: flag = ~less & ~equal;
            CMP_SLE: flag = less | equal;
            CMP_SGE: flag = ~less;
            CMP_SEQ: flag = equal;
            CMP_SNE: flag = ~equal;
            default: cmp_ok = 1'b0;
        endcase

        fin_res_d  = '0;
        fin_cout_d = 1'b0;
        fin_ovf_d  = 1'b0;
        case (op_q)
            OP_AND, OP_OR, OP_NOR: fin_res_d = res_d;
            OP_ADD, OP_SUB: begin
                fin_res_d  = res_d;
                fin_cout_d = sum_ch[SLICE];
                fin_ovf_d  = ovf_d;
            end
            OP_CMP: begin
                if (cmp_ok) begin
                    fin_res_d  = {{(WIDTH-1){1'b0}}, flag};
                    fin_cout_d = sum_ch[SLICE];
                    fin_ovf_d  = ovf_d;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            op_q     <= '0;
            comp_q   <= '0;
            k_q      <= '0;
            carry_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        a_q     <= src1_i;
                        b_q     <= src2_i;
                        op_q    <= op_i;
                        comp_q  <= comp_i;
                        k_q     <= '0;
                        carry_q <= (op_i == OP_SUB) || (op_i == OP_CMP);
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    res_q   <= res_d;
                    carry_q <= sum_ch[SLICE];
                    if (k_q == K_LAST) begin
                        k_q      <= '0;
                        state_q  <= S_FIN;
                        result_q <= fin_res_d;
                        zero_q   <= (fin_res_d == '0);
                        cout_q   <= fin_cout_d;
                        ovf_q    <= fin_ovf_d;
                        done_q   <= 1'b1;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign result_o   = result_q;
    assign zero_o     = zero_q;
    assign cout_o     = cout_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter: stimulus pushes model results, a negedge
// monitor pops and compares them on every done_o pulse.
module tb_alu_iter;

    localparam int WIDTH = 32;
    localparam int SLICE = 8;
    localparam int N     = WIDTH / SLICE;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic              clk_i = 1'b0;
    logic              rst_n, start_i;
    logic [WIDTH-1:0]  src1_i, src2_i, result_o;
    logic [3:0]        op_i;
    logic [2:0]        comp_i;
    logic              busy_o, done_o, zero_o, cout_o, overflow_o;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        cout;
        logic        ovf;
        int          t0;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   ncyc  = 0;

    alu_iter #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk_i(clk_i), .rst_n(rst_n), .start_i(start_i),
        .src1_i(src1_i), .src2_i(src2_i), .op_i(op_i), .comp_i(comp_i),
        .busy_o(busy_o), .done_o(done_o), .result_o(result_o),
        .zero_o(zero_o), .cout_o(cout_o), .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic on whole words.
    function automatic exp_t model(input logic [3:0] op, input logic [2:0] cmp,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa, sb, sr;
        logic   flag;
        logic   valid;
        e.res = '0; e.cout = 1'b0; e.ovf = 1'b0; e.t0 = 0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        flag = 1'b0;
        valid = 1'b1;
        case (op)
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b1100: e.res = ~(a | b);
            4'b0010: begin
                e.res  = a + b;
                e.cout = ({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF;
                sr     = sa + sb;
                e.ovf  = (sr > SMAX) || (sr < SMIN);
            end
            4'b0110, 4'b0111: begin
                e.cout = (a >= b);
                sr     = sa - sb;
                e.ovf  = (sr > SMAX) || (sr < SMIN);
                if (op == 4'b0110) e.res = a - b;
                else begin
                    case (cmp)
                        3'b000:  flag = (sa < sb);
                        3'b001:  flag = (sa > sb);
                        3'b010:  flag = (sa <= sb);
                        3'b011:  flag = (sa >= sb);
                        3'b110:  flag = (sa == sb);
                        3'b100:  flag = (sa != sb);
                        default: valid = 1'b0;
                    endcase
                    if (valid) e.res = {31'd0, flag};
                    else begin
                        e.cout = 1'b0;
                        e.ovf  = 1'b0;
                    end
                end
            end
            default: ;
        endcase
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    always @(negedge clk_i) begin
        ncyc++;
        if (done_o) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done_o=1 at cycle %0d, expected no pulse", ncyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("result",   64'(result_o),   64'(mon_e.res));
                check("zero",     64'(zero_o),     64'(mon_e.zero));
                check("cout",     64'(cout_o),     64'(mon_e.cout));
                check("overflow", 64'(overflow_o), 64'(mon_e.ovf));
                check("latency",  64'(ncyc - mon_e.t0), 64'(N + 1));
            end
        end
    end

    // Called at posedge+1; waits for IDLE, presents one request, scrambles inputs afterwards.
    task automatic issue(input logic [3:0] op, input logic [2:0] cmp, input logic [31:0] a,
                         input logic [31:0] b, input bit push, input bit noise);
        int   g = 0;
        exp_t e;
        while (busy_o && g < 40) begin
            if (noise) begin
                start_i = 1'($urandom);
                src1_i  = $urandom;
                src2_i  = $urandom;
                op_i    = 4'($urandom);
                comp_i  = 3'($urandom);
            end
            @(posedge clk_i); #1;
            g++;
        end
        if (busy_o) begin
            n_vec++;
            n_err++;
            $display("FAIL busy_timeout: busy_o=%b after %0d cycles, expected 0", busy_o, g);
        end
        start_i = 1'b1;
        src1_i  = a;
        src2_i  = b;
        op_i    = op;
        comp_i  = cmp;
        if (push) begin
            e    = model(op, cmp, a, b);
            e.t0 = ncyc + 1;
            exp_q.push_back(e);
        end
        @(posedge clk_i); #1;
        start_i = 1'b0;
        src1_i  = $urandom;
        src2_i  = $urandom;
        op_i    = 4'($urandom);
        comp_i  = 3'($urandom);
    endtask

    task automatic wait_idle();
        int g = 0;
        start_i = 1'b0;
        while ((exp_q.size() != 0 || busy_o) && g < 60) begin
            @(posedge clk_i); #1;
            g++;
        end
        if (exp_q.size() != 0 || busy_o) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending results, busy_o=%b, expected 0 and 0",
                     exp_q.size(), busy_o);
        end
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [3:0] rand_op();
        case ($urandom_range(0, 6))
            0:       return 4'b0000;
            1:       return 4'b0001;
            2:       return 4'b0010;
            3:       return 4'b0110;
            4:       return 4'b1100;
            5:       return 4'b0111;
            default: return 4'($urandom);
        endcase
    endfunction

    logic [2:0] cmp_a[6] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b100};
    logic [2:0] cmp_b[4] = '{3'b110, 3'b010, 3'b011, 3'b000};

    initial begin
        logic [31:0] ra, rb;
        logic [3:0]  rop;

        rst_n = 1'b0; start_i = 1'b0;
        src1_i = '0; src2_i = '0; op_i = '0; comp_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_busy",   64'(busy_o),     64'd0);
        check("rst_done",   64'(done_o),     64'd0);
        check("rst_result", 64'(result_o),   64'd0);
        check("rst_zero",   64'(zero_o),     64'd1);
        check("rst_cout",   64'(cout_o),     64'd0);
        check("rst_ovf",    64'(overflow_o), 64'd0);
        rst_n = 1'b1;
        @(posedge clk_i); #1;

        issue(4'b0010, 3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0);
        issue(4'b0000, 3'b000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b1, 1'b1);
        issue(4'b0001, 3'b000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b1, 1'b1);
        issue(4'b1100, 3'b000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++)
            issue(4'b0111, cmp_a[i], 32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++)
            issue(4'b0111, cmp_b[i], 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1);
        issue(4'b0110, 3'b000, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
        wait_idle();

        // Abort an ADD during chunk 2 with a one-cycle reset pulse.
        issue(4'b0010, 3'b000, 32'h0000_1234, 32'h0000_0001, 1'b0, 1'b0);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy",   64'(busy_o),     64'd0);
        check("abort_done",   64'(done_o),     64'd0);
        check("abort_result", 64'(result_o),   64'd0);
        check("abort_zero",   64'(zero_o),     64'd1);
        check("abort_cout",   64'(cout_o),     64'd0);
        check("abort_ovf",    64'(overflow_o), 64'd0);
        @(posedge clk_i); #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk_i);
        #1;
        check("abort_idle_busy", 64'(busy_o), 64'd0);
        issue(4'b0010, 3'b000, 32'd2, 32'd3, 1'b1, 1'b0);
        wait_idle();

        // start_i held high: one accept every N+2 cycles.
        for (int i = 0; i < 24; i++) begin
            check("hold_busy", 64'(busy_o), 64'((i % (N + 2)) != 0));
            if (!busy_o) begin
                mon_e    = model(4'b0010, 3'b000, 32'h0000_00FF, 32'h0000_0101);
                mon_e.t0 = ncyc + 1;
                exp_q.push_back(mon_e);
            end
            start_i = 1'b1;
            src1_i  = 32'h0000_00FF;
            src2_i  = 32'h0000_0101;
            op_i    = 4'b0010;
            comp_i  = 3'b000;
            @(posedge clk_i); #1;
        end
        start_i = 1'b0;
        wait_idle();

        for (int i = 0; i < 150; i++) begin
            rop = rand_op();
            ra  = rand_word();
            rb  = ($urandom_range(0, 4) == 0) ? ra : rand_word();
            issue(rop, 3'($urandom), ra, rb, 1'b1, 1'b1);
        end
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
